// File: rtl/low_freq_ctrl.sv
// Sequencer for the auto-scaled low-frequency counter: measure period, divide, convert, normalise.
// Optional MEAS watchdog is built when LOW_FREQ_CTRL_TIMEOUT_EN is defined.
module low_freq_ctrl #(
    parameter logic [31:0] DIVIDEND       = 32'd1_000_000,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        start_i,
    output logic        meas_en_o,
    input  logic        period_done_i,
    input  logic [15:0] period_i,
    output logic        div_start_o,
    output logic [31:0] dividend_o,
    output logic [15:0] divisor_o,
    input  logic        div_done_i,
    input  logic [31:0] quotient_i,
    output logic        bcd_start_o,
    output logic [19:0] bin_o,
    input  logic        bcd_done_i,
    input  logic [23:0] bcd_i,
    output logic [15:0] digits_o,
    output logic [2:0]  dp_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_MEAS, S_DIV, S_BCD, S_SCALE, S_DONE, S_ERR
    } state_t;

    localparam logic [31:0] MAX_BIN = 32'd999_999;

    state_t      state_q, state_d;
    logic [15:0] divisor_q;
    logic [19:0] bin_q;
    logic [23:0] sreg_q;
    logic [2:0]  dp_cnt_q;
    logic [15:0] digits_q;
    logic [2:0]  dp_q;
    logic        err_q;
    logic        div_start_q;
    logic        bcd_start_q;

    logic        accept_start;
    logic        take_period;
    logic        take_quot;
    logic        take_bcd;
    logic        do_shift;
    logic        post;
    logic        go_err;
    logic        tmo_hit;
    logic [19:0] q_clamped;

    assign q_clamped = (quotient_i > MAX_BIN) ? MAX_BIN[19:0] : quotient_i[19:0];

`ifdef LOW_FREQ_CTRL_TIMEOUT_EN
    logic [31:0] tmo_cnt_q;

    // Counter reaching the limit on this MEAS cycle means TIMEOUT_CYCLES cycles elapsed.
    assign tmo_hit = (tmo_cnt_q + 32'd1 == TIMEOUT_CYCLES);

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            tmo_cnt_q <= '0;
        end else if (accept_start) begin
            tmo_cnt_q <= '0;
        end else if (state_q == S_MEAS) begin
            tmo_cnt_q <= tmo_cnt_q + 32'd1;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign tmo_hit    = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        accept_start = 1'b0;
        take_period  = 1'b0;
        take_quot    = 1'b0;
        take_bcd     = 1'b0;
        do_shift     = 1'b0;
        post         = 1'b0;
        go_err       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    accept_start = 1'b1;
                    state_d      = S_MEAS;
                end
            end
            S_MEAS: begin
                // A period arriving on the timeout cycle still wins.
                if (period_done_i) begin
                    take_period = 1'b1;
                    if (period_i == 16'd0) begin
                        go_err  = 1'b1;
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DIV;
                    end
                end else if (tmo_hit) begin
                    go_err  = 1'b1;
                    state_d = S_ERR;
                end
            end
            S_DIV: begin
                if (div_done_i) begin
                    take_quot = 1'b1;
                    state_d   = S_BCD;
                end
            end
            S_BCD: begin
                if (bcd_done_i) begin
                    take_bcd = 1'b1;
                    state_d  = S_SCALE;
                end
            end
            S_SCALE: begin
                if (sreg_q[23:20] == 4'd0 && dp_cnt_q < 3'd5) begin
                    do_shift = 1'b1;
                end else begin
                    post    = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q     <= S_IDLE;
            divisor_q   <= '0;
            bin_q       <= '0;
            sreg_q      <= '0;
            dp_cnt_q    <= '0;
            digits_q    <= '0;
            dp_q        <= '0;
            err_q       <= 1'b0;
            div_start_q <= 1'b0;
            bcd_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_start_q <= take_period && (period_i != 16'd0);
            bcd_start_q <= take_quot;
            if (take_period) divisor_q <= period_i;
            if (take_quot)   bin_q     <= q_clamped;
            if (take_bcd) begin
                sreg_q   <= bcd_i;
                dp_cnt_q <= '0;
            end else if (do_shift) begin
                sreg_q   <= {sreg_q[19:0], 4'h0};
                dp_cnt_q <= dp_cnt_q + 3'd1;
            end
            // Result is posted on entry to DONE so it is valid alongside done_o.
            if (post) begin
                digits_q <= sreg_q[23:8];
                dp_q     <= dp_cnt_q;
            end
            if (accept_start)  err_q <= 1'b0;
            else if (go_err)   err_q <= 1'b1;
        end
    end

    assign meas_en_o   = (state_q == S_MEAS);
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign div_start_o = div_start_q;
    assign bcd_start_o = bcd_start_q;
    assign dividend_o  = DIVIDEND;
    assign divisor_o   = divisor_q;
    assign bin_o       = bin_q;
    assign digits_o    = digits_q;
    assign dp_o        = dp_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_low_freq_ctrl.sv
// Randomised self-checking bench for low_freq_ctrl; the bench plays divider and BCD converter.
module tb_low_freq_ctrl;

    localparam logic [31:0] DIVIDEND = 32'd1_000_000;
    localparam logic [31:0] TMO      = 32'd100;

    logic        clk = 1'b0;
    logic        reset_ni = 1'b0;
    logic        start_i = 1'b0;
    logic        meas_en_o;
    logic        period_done_i = 1'b0;
    logic [15:0] period_i = '0;
    logic        div_start_o;
    logic [31:0] dividend_o;
    logic [15:0] divisor_o;
    logic        div_done_i = 1'b0;
    logic [31:0] quotient_i = '0;
    logic        bcd_start_o;
    logic [19:0] bin_o;
    logic        bcd_done_i = 1'b0;
    logic [23:0] bcd_i = '0;
    logic [15:0] digits_o;
    logic [2:0]  dp_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_digits = '0;
    logic [2:0]  exp_dp = '0;

    low_freq_ctrl #(.DIVIDEND(DIVIDEND), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .reset_ni(reset_ni), .start_i(start_i), .meas_en_o(meas_en_o),
        .period_done_i(period_done_i), .period_i(period_i), .div_start_o(div_start_o),
        .dividend_o(dividend_o), .divisor_o(divisor_o), .div_done_i(div_done_i),
        .quotient_i(quotient_i), .bcd_start_o(bcd_start_o), .bin_o(bin_o),
        .bcd_done_i(bcd_done_i), .bcd_i(bcd_i), .digits_o(digits_o), .dp_o(dp_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] to_bcd(input int unsigned v);
        logic [23:0] r = '0;
        int unsigned x = v;
        for (int i = 0; i < 6; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int unsigned to_bcd_val(input logic [15:0] d);
        return d[15:12] * 1000 + d[11:8] * 100 + d[7:4] * 10 + d[3:0];
    endfunction

    // Reference normalisation: left-justify the decimal value in 6 digits (at most 5 shifts),
    // keep the top four digits; dp equals the number of shifts.
    task automatic ref_scale(input int unsigned v, output logic [15:0] dig, output int shift);
        int unsigned nd = 0, x = v, scaled;
        while (x != 0) begin
            nd++;
            x = x / 10;
        end
        shift  = (6 - int'(nd) > 5) ? 5 : 6 - int'(nd);
        scaled = v * (10 ** shift);
        dig    = to_bcd(scaled / 100)[15:0];
    endtask

    task automatic do_txn(input logic [15:0] per, input int d1, input int d2, input int d3);
        int unsigned q, qc;
        logic [15:0] edig;
        int shift, k;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("meas_en", meas_en_o, 1'b1);
        chk("busy", busy_o, 1'b1);
        chk("err_clr", err_o, 1'b0);
        repeat (d1) begin
            div_done_i = 1'b1; bcd_done_i = 1'b1; quotient_i = $urandom;
            tick();
            div_done_i = 1'b0; bcd_done_i = 1'b0;
        end
        period_done_i = 1'b1; period_i = per;
        tick();
        period_done_i = 1'b0; period_i = 16'($urandom);
        if (per == 16'd0) begin
            chk("err_set", err_o, 1'b1);
            chk("no_div_start", div_start_o, 1'b0);
            chk("meas_off", meas_en_o, 1'b0);
            tick();
            chk("err_idle", busy_o, 1'b0);
            chk("err_hold", err_o, 1'b1);
            chk("err_digits", digits_o, exp_digits);
            chk("err_dp", dp_o, exp_dp);
            return;
        end
        chk("div_start", div_start_o, 1'b1);
        chk("divisor", divisor_o, per);
        chk("dividend", dividend_o, DIVIDEND);
        q  = DIVIDEND / per;
        qc = (q > 999_999) ? 999_999 : q;
        repeat (d2) begin
            start_i = 1'b1; period_done_i = 1'b1; period_i = 16'd0; bcd_done_i = 1'b1;
            tick();
            period_done_i = 1'b0; bcd_done_i = 1'b0;
        end
        start_i = 1'b0;
        chk("divisor_hold", divisor_o, per);
        div_done_i = 1'b1; quotient_i = q;
        tick();
        div_done_i = 1'b0; quotient_i = $urandom;
        chk("bcd_start", bcd_start_o, 1'b1);
        chk("bin", bin_o, qc);
        repeat (d3) begin
            period_done_i = 1'b1; div_done_i = 1'b1; period_i = 16'd0;
            tick();
            period_done_i = 1'b0; div_done_i = 1'b0;
        end
        chk("bin_hold", bin_o, qc);
        bcd_done_i = 1'b1; bcd_i = to_bcd(qc);
        tick();
        bcd_done_i = 1'b0; bcd_i = 24'($urandom);
        ref_scale(qc, edig, shift);
        k = 0;
        while (!done_o && k < 20) begin
            tick();
            k++;
        end
        chk("done_lat", k, 1 + shift);
        tick();
        chk("done_pulse", done_o, 1'b0);
        chk("idle", busy_o, 1'b0);
        chk("digits", digits_o, edig);
        chk("dp", dp_o, shift);
        exp_digits = edig;
        exp_dp     = 3'(shift);
    endtask

    initial begin
        int k;
        repeat (3) tick();
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_meas", meas_en_o, 1'b0);
        chk("rst_digits", digits_o, 16'd0);
        chk("rst_dividend", dividend_o, DIVIDEND);
        chk("rst_err", err_o, 1'b0);
        reset_ni = 1'b1;
        tick();

        do_txn(16'd1000, 2, 3, 1);
        chk("t1_dec", to_bcd_val(digits_o), 1000);
        do_txn(16'd3, 0, 0, 0);
        do_txn(16'd65535, 5, 1, 2);
        do_txn(16'd1, 1, 2, 0);
        do_txn(16'd0, 3, 0, 0);
        do_txn(16'd7, 1, 1, 1);
        for (int i = 0; i < 8; i++)
            do_txn(16'($urandom_range(1, 65535)), $urandom_range(0, 20),
                   $urandom_range(0, 5), $urandom_range(0, 5));

        // MEAS with no period
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
`ifdef LOW_FREQ_CTRL_TIMEOUT_EN
        k = 1;
        while (!err_o && k < 2000) begin
            tick();
            k++;
        end
        chk("timeout_cycle", k, 101);
        tick();
        chk("timeout_idle", busy_o, 1'b0);
        chk("timeout_digits", digits_o, exp_digits);
`else
        repeat (1000) tick();
        chk("no_timeout", meas_en_o, 1'b1);
        chk("no_timeout_err", err_o, 1'b0);
        reset_ni = 1'b0;
        tick();
        reset_ni = 1'b1;
        exp_digits = '0;
        exp_dp     = '0;
`endif
        do_txn(16'd250, 1, 0, 0);

        // abort during DIV
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        period_done_i = 1'b1; period_i = 16'd500;
        tick();
        period_done_i = 1'b0;
        tick();
        reset_ni = 1'b0;
        tick();
        reset_ni = 1'b1;
        chk("abort_busy", busy_o, 1'b0);
        chk("abort_divisor", divisor_o, 16'd0);
        chk("abort_digits", digits_o, 16'd0);
        chk("abort_dp", dp_o, 3'd0);
        chk("abort_bin", bin_o, 20'd0);
        chk("abort_done", done_o, 1'b0);
        chk("abort_dividend", dividend_o, DIVIDEND);
        div_done_i = 1'b1; quotient_i = 32'd7;
        tick();
        div_done_i = 1'b0;
        chk("late_div_bcd_start", bcd_start_o, 1'b0);
        chk("late_div_busy", busy_o, 1'b0);
        tick();
        chk("late_div_bin", bin_o, 20'd0);
        exp_digits = '0;
        exp_dp     = '0;
        do_txn(16'd40, 0, 1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/low_freq_ctrl.md
# low_freq_ctrl

Top-level sequencer for the auto-scaled low-frequency counter. On a start request it enables the period counter and captures one input-signal period, measured in reference ticks. It then runs the external divider to form frequency = DIVIDEND / period, and runs the external binary-to-BCD converter. Finally it normalises the 6-digit BCD result into 4 display digits plus a decimal-point index.

## Interface

Parameters:
- DIVIDEND, 1_000_000: constant dividend presented to the divider; 32 bits.
- TIMEOUT_CYCLES, 50_000_000: maximum clk cycles allowed in MEAS; only used with the timeout macro.

Ports:
- clk_i  in  1  clock; the single clock domain.
- reset_ni  in  1  synchronous, active-low reset.
- start_i  in  1  start request; sampled in IDLE only.
- meas_en_o  out  1  level, high in MEAS; gates the edge tick into the period counter.
- period_done_i  in  1  period counter done pulse.
- period_i  in  16  period counter count, valid with period_done_i.
- div_start_o  out  1  one-cycle divider start pulse.
- dividend_o  out  32  constant DIVIDEND.
- divisor_o  out  16  latched period.
- div_done_i  in  1  divider done pulse.
- quotient_i  in  32  divider result, valid with div_done_i.
- bcd_start_o  out  1  one-cycle converter start pulse.
- bin_o  out  20  clamped quotient.
- bcd_done_i  in  1  converter done pulse.
- bcd_i  in  24  6 BCD digits, digit 5 in [23:20].
- digits_o  out  16  4 display digits, most significant in [15:12].
- dp_o  out  3  decimal index; displayed value = digits_o × 10^(2 − dp_o).
- busy_o  out  1  high when state ≠ IDLE.
- done_o  out  1  one-cycle pulse when a new result is posted.
- err_o  out  1  level; set on error, cleared by the next accepted start.

## Operation

States: IDLE, MEAS, DIV, BCD, SCALE, DONE, ERR.

- **IDLE**
  - start_i → MEAS; clear err_o and the timeout counter.
  - Other inputs are ignored.
- **MEAS**
  - meas_en_o = 1.
  - On period_done_i, latch period_i.
  - If period_i == 0 → ERR.
  - Otherwise → DIV, with div_start_o asserted on the transition cycle.
- **DIV**
  - Wait for div_done_i.
  - Clamp: q = min(quotient_i, 999_999); latch q[19:0].
  - → BCD, with bcd_start_o pulsed.
- **BCD**
  - Wait for bcd_done_i; latch bcd_i into the shift register; clear the dp counter.
  - → SCALE.
- **SCALE**
  - Each cycle, while digit 5 == 0 and dp < 5: shift the register left one digit (4 bits, zero fill) and increment dp.
  - When either condition fails → DONE.
  - Takes 1 + number of shifts cycles.
- **DONE**
  - digits_o ← reg[23:8]; dp_o ← dp.
  - done_o = 1 for this cycle; → IDLE.
- **ERR**
  - err_o = 1; digits_o and dp_o keep their previous values.
  - → IDLE next cycle; err_o stays high.

Rules:
- start_i outside IDLE is ignored; there is no queueing.
- Stray period_done_i, div_done_i or bcd_done_i outside their wait states are ignored.
- digits_o and dp_o hold until the next DONE.

## Timing

- Reset (reset_ni low at a clk edge): state → IDLE.
  - All outputs 0 except dividend_o = DIVIDEND.
  - Internal registers 0.
  - Reset mid-operation aborts immediately; no done_o is produced.
- start_i high in IDLE at edge n → meas_en_o high from cycle n+1.
- period_done_i at edge m → div_start_o high in cycle m+1.
- div_done_i at edge k → bcd_start_o high in cycle k+1.
- bcd_done_i at edge j → SCALE in cycle j+1; done_o in cycle j+2+shifts.
- divisor_o and bin_o are stable from their start pulse until the matching done input.

## Configuration

Macro: LOW_FREQ_CTRL_TIMEOUT_EN.

- **Defined**
  - A 32-bit counter increments each MEAS cycle.
  - When it reaches TIMEOUT_CYCLES without period_done_i → ERR.
  - period_done_i in the same cycle takes priority over the timeout.
- **Undefined**
  - No counter is built; MEAS waits indefinitely.
  - TIMEOUT_CYCLES is unused.

## Test plan

- Period = 1000, quotient = 1000, bcd = 0x001000 → two shifts; digits_o = 0x1000, dp_o = 2, done_o pulses once, busy_o low afterwards.
- Period = 3, quotient = 333_333 → no shift; digits_o = 0x3333, dp_o = 0.
- Period = 65535, quotient = 15, bcd = 0x000015 → four shifts; digits_o = 0x1500, dp_o = 4; done_o arrives 6 cycles after bcd_done_i.
- Quotient = 1_000_000 → bin_o = 999_999.
- Period = 0 → err_o = 1; no div_start_o; digits_o and dp_o unchanged; next start_i clears err_o.
- With the macro and TIMEOUT_CYCLES = 100, no period_done_i → ERR after 100 MEAS cycles. Without the macro → still in MEAS after 1000 cycles.
- reset_ni low during DIV → IDLE, all outputs 0. A late div_done_i is ignored. start_i during busy has no effect.
